// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and width helper
// for the UART TX write-port arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        HOLD  = 2'b10
    } arb_state_t;

    // ceil(log2(n)) for n >= 1
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bundle plus TX FIFO write side.
// master = producers/FIFO side, slave = arbiter.
interface uart_tx_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DBITS = 8
);
    import uart_arb_pkg::*;

    localparam int GW = clog2_f(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DBITS-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  tx_full;
    logic                  write_uart;
    logic [DBITS-1:0]      write_data;
    logic [GW-1:0]         grant_id;
    logic                  busy;
    logic                  timeout_flag;

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, write_uart, write_data,
        input  grant_id, busy, timeout_flag
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, write_uart, write_data,
        output grant_id, busy, timeout_flag
    );

endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker.
// Ports: req (requests), ptr (last winner) -> gnt_idx, any.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int GW   = clog2_f(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic [GW-1:0]   gnt_idx,
    output logic            any
);

    function automatic logic [GW-1:0] slot(
        input logic [GW-1:0] p,
        input int            k
    );
        return GW'((int'(p) + k) % NREQ);
    endfunction

    // Walk from lowest priority to highest so the
    // final hit is the first requester after ptr.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[slot(ptr, k)]) begin
                gnt_idx = slot(ptr, k);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet round-robin arbiter for the UART TX FIFO
// write port. Ports: clk_100MHz, reset_btn (async, high), bus (slave:
// req_valid/data/last/ready, tx_full, write_uart/data, grant_id,
// busy, timeout_flag). Optional macro: UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DBITS   = 8,
    parameter int TIMEOUT = 1024,
    parameter int TO_BITS = 11
) (
    input logic              clk_100MHz,
    input logic              reset_btn,
    uart_tx_arbiter_if.slave bus
);

    localparam int GW = clog2_f(NREQ);

    generate
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("uart_tx_arbiter: NREQ must be 2..8");
        end
        if ((1 << TO_BITS) <= TIMEOUT) begin : g_bad_to
            $error("uart_tx_arbiter: TO_BITS too small");
        end
    endgenerate

    arb_state_t       state;
    arb_state_t       state_d;
    logic [GW-1:0]    gid_q;
    logic [GW-1:0]    ptr_q;
    logic [GW-1:0]    pick_idx;
    logic             pick_any;
    logic             done_q;
    logic             wu_q;
    logic [DBITS-1:0] wd_q;
    logic [NREQ-1:0]  ready;
    logic             xfer;
    logic             cur_valid;
    logic             cur_last;
    logic [DBITS-1:0] cur_data;
    logic             to_hit;

    assign cur_valid = bus.req_valid[gid_q];
    assign cur_last  = bus.req_last[gid_q];
    assign cur_data  = bus.req_data[gid_q*DBITS +: DBITS];

    uart_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        state_d = state;
        ready   = '0;
        xfer    = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_any) state_d = GRANT;
            end
            GRANT: begin
                ready[gid_q] = ~bus.tx_full;
                xfer         = cur_valid & ~bus.tx_full;
                if (xfer) begin
                    state_d = HOLD;
                end else if (to_hit) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                // One dead cycle lets tx_full catch up
                // with the word just written.
                state_d = done_q ? IDLE : GRANT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset_btn) begin
        if (reset_btn) state <= IDLE;
        else           state <= state_d;
    end

    always_ff @(posedge clk_100MHz or posedge reset_btn) begin
        if (reset_btn) begin
            gid_q  <= '0;
            ptr_q  <= GW'(NREQ - 1);
            done_q <= 1'b0;
            wu_q   <= 1'b0;
            wd_q   <= '0;
        end else begin
            wu_q <= xfer;
            if (state == IDLE && pick_any) gid_q <= pick_idx;
            if (xfer) begin
                wd_q   <= cur_data;
                done_q <= cur_last;
            end
            if ((xfer && cur_last) || to_hit) ptr_q <= gid_q;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [TO_BITS-1:0] to_cnt;
    logic               to_flag_q;

    // Only a silent holder counts; tx_full stalls with
    // valid high leave the count untouched.
    assign to_hit = (state == GRANT) && !cur_valid &&
                    (to_cnt == TO_BITS'(TIMEOUT - 1));

    always_ff @(posedge clk_100MHz or posedge reset_btn) begin
        if (reset_btn) begin
            to_cnt    <= '0;
            to_flag_q <= 1'b0;
        end else begin
            to_flag_q <= to_hit;
            if (state != GRANT || xfer) begin
                to_cnt <= '0;
            end else if (!cur_valid) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign bus.timeout_flag = to_flag_q;
`else
    assign to_hit           = 1'b0;
    assign bus.timeout_flag = 1'b0;
`endif

    assign bus.req_ready  = ready;
    assign bus.write_uart = wu_q;
    assign bus.write_data = wd_q;
    assign bus.grant_id   = gid_q;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed packet sequences and
// random packet traffic checked against a packet-level RR model.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int DBITS = 8;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TOV = 8;
`else
    localparam int TOV = 1024;
`endif

    logic clk_100MHz = 1'b0;
    logic reset_btn  = 1'b0;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_tx_arbiter_if #(.NREQ(NREQ), .DBITS(DBITS)) bus ();

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .DBITS   (DBITS),
        .TIMEOUT (TOV),
        .TO_BITS (11)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset_btn  (reset_btn),
        .bus        (bus)
    );

    typedef struct {
        logic [3:0] m1;
        logic [3:0] m2;
        logic [1:0] g1;
        logic [1:0] g2;
    } vec_t;

    vec_t vecs [7];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [8:0] q [NREQ][$];
    logic [7:0] exp_d [$];
    int         exp_g [$];
    int         wr_cyc [$];
    int         wr_gid [$];
    int         wu_count;

    logic [NREQ-1:0] hold_off  = '0;
    logic            txf       = 1'b0;
    bit              rand_full = 1'b0;
    logic            prev_wu   = 1'b0;

    logic [NREQ-1:0] s_rdy;
    logic [NREQ-1:0] s_xfer;
    logic            s_wu;
    logic            s_busy;
    logic            s_to;
    logic [7:0]      s_wd;
    logic [1:0]      s_gid;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < NREQ; i++)
            if (q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add_pkt(input int i, input int len,
                           input logic [7:0] base);
        for (int k = 0; k < len; k++)
            q[i].push_back({(k == len - 1), base + 8'(k)});
    endtask

    // Packet-level round robin: every requester with queued words
    // is asking; the winner sends a whole packet, then becomes the
    // lowest priority.
    task automatic model(input int ptr);
        logic [8:0] m [NREQ][$];
        logic [8:0] w;
        int         r;
        int         idx;
        bit         more;
        m = q;
        exp_d.delete();
        exp_g.delete();
        more = 1'b1;
        while (more) begin
            r = -1;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (ptr + k) % NREQ;
                if (r < 0 && m[idx].size() > 0) r = idx;
            end
            if (r < 0) begin
                more = 1'b0;
            end else begin
                do begin
                    w = m[r].pop_front();
                    exp_d.push_back(w[7:0]);
                    exp_g.push_back(r);
                end while (!w[8] && m[r].size() > 0);
                ptr = r;
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (q[i].size() > 0 && !hold_off[i]) begin
                bus.req_valid[i] = 1'b1;
                bus.req_data[i*DBITS +: DBITS] = q[i][0][7:0];
                bus.req_last[i] = q[i][0][8];
            end else begin
                bus.req_valid[i] = 1'b0;
                bus.req_data[i*DBITS +: DBITS] = '0;
                bus.req_last[i] = 1'b0;
            end
        end
        if (rand_full) bus.tx_full = ($urandom_range(0, 9) < 3);
        else           bus.tx_full = txf;
    endtask

    task automatic tick();
        logic [7:0] word;
        drive();
        #1;
        s_rdy  = bus.req_ready;
        s_xfer = bus.req_ready & bus.req_valid;
        chk("ready_onehot", $countones(s_rdy) <= 1, 1);
        if (bus.tx_full) chk("ready_while_full", s_rdy, 0);
        word = '0;
        for (int i = 0; i < NREQ; i++)
            if (s_xfer[i]) word = q[i][0][7:0];
        @(posedge clk_100MHz);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++)
            if (s_xfer[i]) void'(q[i].pop_front());
        s_wu   = bus.write_uart;
        s_wd   = bus.write_data;
        s_gid  = bus.grant_id;
        s_busy = bus.busy;
        s_to   = bus.timeout_flag;
        chk("strobe_follows_xfer", s_wu, |s_xfer);
        if (s_xfer != '0) chk("strobe_data", s_wd, word);
        chk("strobe_gap", prev_wu & s_wu, 0);
        prev_wu = s_wu;
        if (s_wu) begin
            wu_count++;
            wr_cyc.push_back(cyc);
            wr_gid.push_back(int'(s_gid));
            chk("write_expected", exp_d.size() > 0, 1);
            if (exp_d.size() > 0) begin
                chk("write_data", s_wd, exp_d.pop_front());
                chk("write_gid", s_gid, exp_g.pop_front());
            end
        end
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && (pending() || bus.busy)) begin
            tick();
            n++;
        end
        chk("run_finished", n < budget, 1);
        chk("all_written", exp_d.size(), 0);
    endtask

    task automatic wait_write(input int budget);
        int n;
        n = 0;
        while (wu_count == 0 && n < budget) begin
            tick();
            n++;
        end
        chk("first_write_seen", wu_count, 1);
    endtask

    task automatic clear_tb();
        for (int i = 0; i < NREQ; i++) q[i].delete();
        exp_d.delete();
        exp_g.delete();
        wr_cyc.delete();
        wr_gid.delete();
        wu_count  = 0;
        hold_off  = '0;
        txf       = 1'b0;
        rand_full = 1'b0;
        prev_wu   = 1'b0;
    endtask

    task automatic do_reset();
        reset_btn = 1'b1;
        clear_tb();
        drive();
        repeat (2) @(posedge clk_100MHz);
        #1;
        reset_btn = 1'b0;
    endtask

    task automatic raw_set(input logic [3:0] m);
        bus.req_valid = m;
        bus.req_last  = '1;
        bus.tx_full   = 1'b0;
        for (int i = 0; i < NREQ; i++)
            bus.req_data[i*DBITS +: DBITS] = 8'h10 + 8'(i);
    endtask

    task automatic raw_cycle();
        @(posedge clk_100MHz);
        #1;
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int to_n;
        int to_at;
        int tot;
        int rr_exp [4];

        vecs[0] = '{4'b0001, 4'b0001, 2'd0, 2'd0};
        vecs[1] = '{4'b1010, 4'b1010, 2'd1, 2'd3};
        vecs[2] = '{4'b1000, 4'b1001, 2'd3, 2'd0};
        vecs[3] = '{4'b1111, 4'b1111, 2'd0, 2'd1};
        vecs[4] = '{4'b0110, 4'b0011, 2'd1, 2'd0};
        vecs[5] = '{4'b1100, 4'b0110, 2'd2, 2'd1};
        vecs[6] = '{4'b0100, 4'b1111, 2'd2, 2'd3};
        rr_exp  = '{0, 2, 0, 2};

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_full   = 1'b0;

        // Reset values
        do_reset();
        chk("rst_write_uart", bus.write_uart, 0);
        chk("rst_write_data", bus.write_data, 0);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_timeout", bus.timeout_flag, 0);
        chk("rst_ready", bus.req_ready, 0);

        // Arbitration table: first pick from reset, then next pick
        for (int v = 0; v < 7; v++) begin
            do_reset();
            raw_set(vecs[v].m1);
            raw_cycle();
            chk("tbl_g1", bus.grant_id, vecs[v].g1);
            chk("tbl_busy", bus.busy, 1);
            raw_cycle();
            chk("tbl_wu", bus.write_uart, 1);
            chk("tbl_wd", bus.write_data, 8'h10 + 8'(vecs[v].g1));
            raw_set(vecs[v].m2);
            raw_cycle();
            chk("tbl_idle", bus.busy, 0);
            raw_cycle();
            chk("tbl_g2", bus.grant_id, vecs[v].g2);
        end

        // Single packet 0x41..0x43 from req0
        do_reset();
        add_pkt(0, 3, 8'h41);
        model(NREQ - 1);
        run_idle(100);
        chk("sp_writes", wr_cyc.size(), 3);
        if (wr_cyc.size() == 3) begin
            chk("sp_gap1", wr_cyc[1] - wr_cyc[0], 2);
            chk("sp_gap2", wr_cyc[2] - wr_cyc[1], 2);
            chk("sp_busy_drop", cyc, wr_cyc[2] + 1);
        end

        // Round robin req0/req2, two packets each
        do_reset();
        add_pkt(0, 2, 8'hA0);
        add_pkt(2, 2, 8'hC0);
        add_pkt(0, 2, 8'hA2);
        add_pkt(2, 2, 8'hC2);
        model(NREQ - 1);
        run_idle(200);
        chk("rr_writes", wr_gid.size(), 8);
        for (int k = 0; k < 4; k++)
            if (wr_gid.size() > 2 * k)
                chk("rr_gid", wr_gid[2*k], rr_exp[k]);

        // Backpressure on req1
        do_reset();
        add_pkt(1, 3, 8'h51);
        model(NREQ - 1);
        wait_write(20);
        txf = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_ready1", s_rdy[1], 0);
            chk("bp_no_write", s_wu, 0);
        end
        txf = 1'b0;
        run_idle(100);
        chk("bp_total", wu_count, 3);

`ifndef UART_ARB_TIMEOUT_EN
        // Holder goes quiet; grant is kept until its last word
        do_reset();
        add_pkt(3, 3, 8'h31);
        model(NREQ - 1);
        wait_write(20);
        hold_off[3] = 1'b1;
        add_pkt(0, 1, 8'h01);
        exp_d.push_back(8'h01);
        exp_g.push_back(0);
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("st_gid", s_gid, 3);
            chk("st_busy", s_busy, 1);
            chk("st_no_write", s_wu, 0);
        end
        hold_off[3] = 1'b0;
        run_idle(100);
        chk("st_total", wu_count, 4);
`else
        // Holder goes quiet; grant revoked after TOV idle cycles
        do_reset();
        add_pkt(3, 3, 8'h31);
        model(NREQ - 1);
        wait_write(20);
        hold_off[3] = 1'b1;
        add_pkt(0, 1, 8'h01);
        exp_d.delete();
        exp_g.delete();
        exp_d = '{8'h01, 8'h32, 8'h33};
        exp_g = '{0, 3, 3};
        to_n  = 0;
        to_at = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (to_at > 0 && k == to_at + 1)
                chk("to_gid_next", s_gid, 0);
            if (s_to) begin
                to_n++;
                if (to_at < 0) to_at = k;
            end
        end
        chk("to_pulses", to_n, 1);
        chk("to_when", to_at, TOV + 1);
        hold_off[3] = 1'b0;
        run_idle(100);
`endif

        // Reset during HOLD
        do_reset();
        add_pkt(0, 2, 8'h61);
        model(NREQ - 1);
        wait_write(20);
        #2;
        reset_btn = 1'b1;
        #1;
        chk("mid_rst_wu", bus.write_uart, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ready", bus.req_ready, 0);
        chk("mid_rst_wd", bus.write_data, 0);
        clear_tb();
        add_pkt(2, 1, 8'h72);
        add_pkt(0, 2, 8'h61);
        model(NREQ - 1);
        drive();
        #1;
        chk("mid_rst_ready_held", bus.req_ready, 0);
        reset_btn = 1'b0;
        run_idle(100);
        chk("mid_rst_writes", wr_gid.size(), 3);
        if (wr_gid.size() > 0) chk("mid_rst_first", wr_gid[0], 0);

        // Random packet traffic with random FIFO-full
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int i = 0; i < NREQ; i++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++)
                    add_pkt(i, $urandom_range(1, 4), 8'($urandom));
            end
            model(NREQ - 1);
            tot = exp_d.size();
            rand_full = 1'b1;
            run_idle(3000);
            chk("rnd_count", wu_count, tot);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
